// File: rtl/reg_bus_ctrl.sv
// Sequencing controller for four shared-bus registers. It arbitrates requesters
// round-robin and drives the oe/ld/rclr lines of the bank in a contention-free order.
module reg_bus_ctrl #(
  parameter int unsigned NREQ = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    src_sel,
  input  logic [2*NREQ-1:0]    dst_sel,
  input  logic [NREQ-1:0]      op,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [3:0]           oe,
  output logic [3:0]           ld,
  output logic [3:0]           rclr,
  output logic                 busy
);

  localparam int unsigned IW = $clog2(NREQ);

  typedef enum logic [2:0] {IDLE, DRIVE, LOAD, CLEAR, DONE} state_t;

  state_t        state, state_n;
  logic [IW-1:0] ptr, ptr_n;
  logic [1:0]    src, src_n;
  logic [1:0]    dst, dst_n;
  logic          found;
  logic [IW-1:0] pick;

  // Round-robin search starting one past the last winner.
  always_comb begin : arb
    logic [IW-1:0] idx;
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = IW'((32'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // ptr doubles as the latched winner index: it is only decoded outside IDLE,
  // and every grant loads it with the winner anyway.
  always_comb begin : fsm
    state_n = state;
    ptr_n   = ptr;
    src_n   = src;
    dst_n   = dst;
    case (state)
      IDLE: begin
        if (found) begin
          ptr_n   = pick;
          src_n   = src_sel[{pick, 1'b0} +: 2];
          dst_n   = dst_sel[{pick, 1'b0} +: 2];
          state_n = op[pick] ? CLEAR : DRIVE;
        end
      end
      DRIVE:   state_n = LOAD;
      LOAD:    state_n = DONE;
      CLEAR:   state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      ptr   <= IW'(NREQ - 1);
      src   <= '0;
      dst   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      src   <= src_n;
      dst   <= dst_n;
    end
  end

  always_comb begin : decode
    gnt  = '0;
    done = '0;
    oe   = '1;
    ld   = '0;
    rclr = '0;
    busy = (state != IDLE);
    if (state != IDLE) gnt[ptr] = 1'b1;
    case (state)
      DRIVE: oe[src] = 1'b0;
      LOAD: begin
        oe[src] = 1'b0;
        ld[dst] = 1'b1;
      end
      CLEAR:   rclr[dst] = 1'b1;
      DONE:    done[ptr] = 1'b1;
      default: ;
    endcase
  end

endmodule
